ace_ccu_snoop_req: RTL

Upstream companion of the CCU snoop-response combiner. Takes one snoop request (AC beat) plus its control word, broadcasts the AC beat to every snooped port selected by ctrl.sel, and only then retires the request. On retirement it pushes the control word into an internal FIFO. The FIFO output is the ctrl_valid/ctrl_ready stream consumed by the response combiner, so response merging follows snoop issue order.

---
 rtl/ace_ccu_snoop_req.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ace_ccu_snoop_req.sv
// Snoop request broadcaster for the CCU.
// Broadcasts one AC snoop beat to every port selected by ctrl_i.sel. The
// request retires only after each selected port has taken it exactly once.
// On retirement the control word is queued for the snoop-response combiner,
// so responses are merged in the same order the snoops were issued.
//
// Handshake semantics, for every valid/ready pair of this block: a transfer
// happens in a cycle where valid and ready are both high at the rising edge.
// A source keeps valid and its payload stable until that transfer. Valid never
// depends combinationally on the ready of the same channel.

package ace_ccu_snoop_req_pkg;
    // Default control word: a lone one-bit target select matching NumOup = 1.
    typedef struct packed {
        logic [0:0] sel;
    } ctrl_default_t;
endpackage

module ace_ccu_snoop_req #(
    parameter int unsigned NumOup        = 1,
    parameter int unsigned CtrlFifoDepth = 2,
    parameter type         ac_chan_t     = logic,
    parameter type         ctrl_t        = ace_ccu_snoop_req_pkg::ctrl_default_t,
    localparam int unsigned CntW         = $clog2(CtrlFifoDepth + 1),
    localparam int unsigned PtrW         = (CtrlFifoDepth > 1) ? $clog2(CtrlFifoDepth) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // Incoming snoop request plus its control word
    input  logic                    ac_valid_i,
    output logic                    ac_ready_o,
    input  ac_chan_t                ac_chan_i,
    input  ctrl_t                   ctrl_i,
    // Per-port snoop requests
    output logic [NumOup-1:0]       ac_valids_o,
    input  logic [NumOup-1:0]       ac_readies_i,
    output ac_chan_t [NumOup-1:0]   ac_chans_o,
    // Control word stream towards the response combiner
    output logic                    ctrl_valid_o,
    input  logic                    ctrl_ready_i,
    output ctrl_t                   ctrl_o,
    output logic [CntW-1:0]         ctrl_count_o
);

    localparam logic [CntW-1:0] CountFull = CntW'(CtrlFifoDepth);
    localparam logic [PtrW-1:0] PtrLast   = PtrW'(CtrlFifoDepth - 1);

    // ------------------------------------------------------------------
    // Broadcast tracking
    // ------------------------------------------------------------------
    logic [NumOup-1:0] sel;
    logic [NumOup-1:0] sent_q, sent_d;
    logic [NumOup-1:0] port_valid;
    logic [NumOup-1:0] port_hs;
    logic              full;
    logic              done;

    // FIFO state
    ctrl_t             mem_q [CtrlFifoDepth];
    ctrl_t             mem_d [CtrlFifoDepth];
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              push;
    logic              pop;

    assign sel = ctrl_i.sel;

    // Issue to every selected port not yet served; hold everything back while
    // the FIFO is full so each issued snoop already owns a FIFO slot.
    always_comb begin
        full       = (count_q == CountFull);
        port_valid = {NumOup{ac_valid_i & ~full}} & sel & ~sent_q;
        port_hs    = port_valid & ac_readies_i;
        done       = ac_valid_i & ~full & (((sent_q | port_hs) & sel) == sel);
    end

    // Every port sees the same payload; only the valids differ.
    always_comb begin
        for (int j = 0; j < NumOup; j++) begin
            ac_chans_o[j] = ac_chan_i;
        end
    end

    assign ac_valids_o = port_valid;
    assign ac_ready_o  = done;

    // Remember which ports have taken the current request; forget on retire.
    always_comb begin
        sent_d = sent_q | port_hs;
        if (done) begin
            sent_d = '0;
        end
    end

    // Served-port register, cleared by reset so a reset request restarts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

    // ------------------------------------------------------------------
    // Control FIFO (registered output, no fall-through)
    // ------------------------------------------------------------------
    assign push = done;
    assign pop  = (count_q != '0) & ctrl_ready_i;

    // Next pointers, occupancy and storage contents.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        mem_d   = mem_q;

        if (push) begin
            mem_d[wptr_q] = ctrl_i;
            wptr_d        = (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign ctrl_valid_o = (count_q != '0);
    assign ctrl_o       = mem_q[rptr_q];
    assign ctrl_count_o = count_q;

endmodule
